// File: rtl/wrt_buf_d_if.sv
// wrt_buf_d_if: write-burst channel between the write-back buffer and the bus bridge
interface wrt_buf_d_if #(parameter int ADDR_W = 32);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_rdy;
  logic [31:0]       w_data;
  logic              w_valid;
  logic              w_last;
  logic              w_ready;
  logic              b_valid;
  modport master (output wr_req, wr_addr, w_data, w_valid, w_last, input wr_rdy, w_ready, b_valid);
  modport slave  (input wr_req, wr_addr, w_data, w_valid, w_last, output wr_rdy, w_ready, b_valid);
endinterface

// File: rtl/wrt_buf_d.sv
// wrt_buf_d: D-cache write-back buffer draining one victim line as a WORDS-beat write burst
module wrt_buf_d #(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wbuf_req,
  input  logic [ADDR_W-1:0]     wbuf_addr,
  input  logic [32*WORDS-1:0]   wbuf_line,
  output logic                  wbuf_busy,
  output logic                  wbuf_done,
  wrt_buf_d_if.master           bus
);
  localparam int CW = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(63);
  typedef enum logic [1:0] {IDLE, REQ, DATA, RESP} state_t;
  state_t              state;
  logic [CW-1:0]       count;
  logic [32*WORDS-1:0] line;
  logic [ADDR_W-1:0]   addr;
  logic                last;
  assign last = count == CW'(WORDS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      line      <= '0;
      addr      <= '0;
      wbuf_done <= 1'b0;
    end else begin
      wbuf_done <= 1'b0;
      case (state)
        IDLE: if (wbuf_req) begin
          line  <= wbuf_line;
          addr  <= wbuf_addr & ~LINE_MASK;
          state <= REQ;
        end
        REQ: if (bus.wr_rdy) begin
          count <= '0;
          state <= DATA;
        end
        DATA: if (bus.w_ready) begin
          count <= last ? '0 : count + 1'b1;
          if (last) state <= RESP;
        end
        RESP: if (bus.b_valid) begin
          wbuf_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  assign wbuf_busy   = state != IDLE;
  assign bus.wr_req  = state == REQ;
  assign bus.wr_addr = addr;
  assign bus.w_valid = state == DATA;
  assign bus.w_data  = bus.w_valid ? line[32*count +: 32] : '0;
  assign bus.w_last  = bus.w_valid && last;
endmodule

// File: tb/tb_wrt_buf_d.sv
// tb_wrt_buf_d: directed checks of the write-back buffer burst sequencing
module tb_wrt_buf_d;
  logic         clk;
  logic         rst;
  logic         wbuf_req;
  logic [31:0]  wbuf_addr;
  logic [511:0] wbuf_line;
  logic         wbuf_busy;
  logic         wbuf_done;
  int           checks;
  int           errors;
  wrt_buf_d_if #(.ADDR_W(32)) bus ();
  wrt_buf_d #(.WORDS(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .wbuf_req(wbuf_req), .wbuf_addr(wbuf_addr), .wbuf_line(wbuf_line),
    .wbuf_busy(wbuf_busy), .wbuf_done(wbuf_done), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [511:0] mk_line(input logic [31:0] base);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction
  task automatic capture(input logic [31:0] a, input logic [31:0] base);
    wbuf_req  = 1'b1;
    wbuf_addr = a;
    wbuf_line = mk_line(base);
    @(negedge clk);
    wbuf_req  = 1'b0;
    wbuf_addr = '0;
    wbuf_line = mk_line(32'hDEAD_0000);
    chk("req_busy", 64'(wbuf_busy), 64'd1);
    chk("req_wr_req", 64'(bus.wr_req), 64'd1);
    chk("req_addr", 64'(bus.wr_addr), 64'(a & ~32'h3F));
  endtask
  task automatic drain(input logic [31:0] a, input logic [31:0] base, input int rdy_dly, input bit bp,
                       input bit inj, input bit bsame, input int bdly, input bit b2b,
                       input logic [31:0] na, input logic [31:0] nbase);
    int  idx;
    int  cyc;
    bit  rdy;
    for (int c = 0; c < rdy_dly; c++) begin
      chk("hold_wr_req", 64'(bus.wr_req), 64'd1);
      chk("hold_addr", 64'(bus.wr_addr), 64'(a & ~32'h3F));
      chk("hold_w_valid", 64'(bus.w_valid), 64'd0);
      @(negedge clk);
    end
    bus.wr_rdy = 1'b1;
    chk("rdy_w_valid", 64'(bus.w_valid), 64'd0);
    @(negedge clk);
    bus.wr_rdy = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 200) begin
      chk("w_valid", 64'(bus.w_valid), 64'd1);
      chk("w_data", 64'(bus.w_data), 64'(base + 32'(idx)));
      chk("w_last", 64'(bus.w_last), 64'(idx == 15));
      rdy = bp ? (cyc % 3 == 0) : 1'b1;
      bus.w_ready = rdy;
      bus.b_valid = bsame && rdy && idx == 15;
      wbuf_req    = inj && cyc == 4;
      if (inj && cyc == 4) begin
        wbuf_addr = 32'h7700_0000;
        wbuf_line = mk_line(32'h5500_0000);
      end
      if (rdy) idx++;
      cyc++;
      @(negedge clk);
    end
    bus.w_ready = 1'b0;
    bus.b_valid = 1'b0;
    wbuf_req    = 1'b0;
    chk("handshakes", 64'(idx), 64'd16);
    for (int c = 0; c < bdly; c++) begin
      chk("resp_w_valid", 64'(bus.w_valid), 64'd0);
      chk("resp_busy", 64'(wbuf_busy), 64'd1);
      chk("resp_done", 64'(wbuf_done), 64'd0);
      @(negedge clk);
    end
    bus.b_valid = 1'b1;
    @(negedge clk);
    bus.b_valid = 1'b0;
    chk("done", 64'(wbuf_done), 64'd1);
    chk("done_busy", 64'(wbuf_busy), 64'd0);
    if (b2b) begin
      capture(na, nbase);
      chk("b2b_done_clr", 64'(wbuf_done), 64'd0);
    end else begin
      @(negedge clk);
      chk("done_clr", 64'(wbuf_done), 64'd0);
      chk("idle_wr_req", 64'(bus.wr_req), 64'd0);
      chk("idle_busy", 64'(wbuf_busy), 64'd0);
    end
  endtask
  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    wbuf_req    = 1'b0;
    wbuf_addr   = '0;
    wbuf_line   = '0;
    bus.wr_rdy  = 1'b0;
    bus.w_ready = 1'b0;
    bus.b_valid = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(wbuf_busy), 64'd0);
    chk("rst_done", 64'(wbuf_done), 64'd0);
    chk("rst_wr_req", 64'(bus.wr_req), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_w_data", 64'(bus.w_data), 64'd0);
    chk("rst_w_valid", 64'(bus.w_valid), 64'd0);
    chk("rst_w_last", 64'(bus.w_last), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    capture(32'h1C00_0047, 32'hA000_0000);
    drain(32'h1C00_0047, 32'hA000_0000, 0, 0, 0, 0, 1, 0, 0, 0);
    capture(32'h2000_0100, 32'hB000_0000);
    drain(32'h2000_0100, 32'hB000_0000, 0, 1, 0, 1, 2, 0, 0, 0);
    capture(32'h3000_00FF, 32'hC000_0000);
    drain(32'h3000_00FF, 32'hC000_0000, 5, 0, 0, 0, 0, 0, 0, 0);
    capture(32'h4000_0000, 32'hD000_0000);
    drain(32'h4000_0000, 32'hD000_0000, 0, 0, 1, 0, 1, 0, 0, 0);
    capture(32'h4800_0000, 32'hF000_0000);
    drain(32'h4800_0000, 32'hF000_0000, 0, 0, 0, 0, 1, 1, 32'h5000_00BF, 32'hE000_0000);
    drain(32'h5000_00BF, 32'hE000_0000, 1, 0, 0, 0, 0, 0, 0, 0);
    capture(32'h6000_0000, 32'h7000_0000);
    bus.wr_rdy = 1'b1;
    @(negedge clk);
    bus.wr_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("pre_rst_data", 64'(bus.w_data), 64'(32'h7000_0000 + 32'(i)));
      bus.w_ready = 1'b1;
      @(negedge clk);
    end
    bus.w_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(wbuf_busy), 64'd0);
    chk("arst_w_valid", 64'(bus.w_valid), 64'd0);
    chk("arst_w_data", 64'(bus.w_data), 64'd0);
    chk("arst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("arst_w_last", 64'(bus.w_last), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 64'(wbuf_done), 64'd0);
    chk("post_rst_busy", 64'(wbuf_busy), 64'd0);
    chk("post_rst_wr_req", 64'(bus.wr_req), 64'd0);
    capture(32'h6100_0040, 32'h8000_0000);
    drain(32'h6100_0040, 32'h8000_0000, 0, 0, 0, 0, 1, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wrt_buf_d.md
Name: wrt_buf_d

Overview:
- D-cache write-back buffer: the transmit side of the line-transfer path.
- Accepts one dirty 512-bit victim line plus its address from the cache FSM in a single cycle.
- Issues the write burst request, then streams the line out as 16 32-bit words in ascending word order (word 0 = bits [31:0] first), then waits for the write response.
- Frees the cache immediately after capture, so refill through the return buffer can proceed while the eviction drains.

Parameters:
- WORDS, 16, words per cache line; line width is 32*WORDS; counter width is log2(WORDS).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wbuf_req  in  1  cache requests capture of a victim line.
- wbuf_addr  in  ADDR_W  victim line address; low 6 bits ignored.
- wbuf_line  in  32*WORDS  victim line data.
- wbuf_busy  out  1  buffer holds an undrained line.
- wbuf_done  out  1  one-cycle pulse: write response received.
- wr_req  out  1  burst write request to the bus bridge.
- wr_addr  out  ADDR_W  burst start address, line-aligned.
- wr_rdy  in  1  bridge accepts wr_req.
- w_data  out  32  current data word.
- w_valid  out  1  w_data valid.
- w_last  out  1  final word of the burst.
- w_ready  in  1  bridge accepts the current word.
- b_valid  in  1  write response from the bridge.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, count=0, latched line/addr=0.
  - All outputs 0: wbuf_busy, wbuf_done, wr_req, wr_addr, w_data, w_valid, w_last.
  - A reset mid-transfer abandons the line; no wbuf_done is produced.
- FSM states: IDLE, REQ, DATA, RESP. Outputs are decoded from registered state and count.
- IDLE:
  - wbuf_busy=0.
  - On wbuf_req=1: latch line and {wbuf_addr[ADDR_W-1:6], 6'b0}, go to REQ.
  - wbuf_busy=1 from the next cycle.
- REQ:
  - wr_req=1, wr_addr=latched address, held stable until wr_rdy.
  - On wr_rdy=1: count<=0, go to DATA.
- DATA:
  - w_valid=1, w_data=line[32*count +: 32], w_last=(count==WORDS-1).
  - On w_valid & w_ready: count<=count+1. If the word was the last: count<=0, go to RESP.
  - If w_ready=0: w_data, w_last and count hold.
- RESP:
  - w_valid=0, waiting for the response.
  - On b_valid=1: go to IDLE; wbuf_done=1 for exactly the next cycle.
- wbuf_busy=1 in REQ, DATA and RESP.
- Request latency: minimum 1 cycle from wbuf_req to wr_req.
- Full transfer: minimum 1 (REQ) + 16 (DATA) + 1 (RESP) cycles.
- Boundary conditions:
  - wbuf_req while busy: ignored, latched line untouched. The cache must hold the line until wbuf_busy=0.
  - wbuf_req in the same cycle wbuf_done is high: legal, since state is already IDLE, and the request is captured.
  - b_valid outside RESP, including in the same cycle as the last W handshake: ignored.
  - wr_rdy outside REQ, w_ready outside DATA: ignored.
  - Count wraps at WORDS-1 only via the DATA->RESP transition, never by overflow.

Test Plan:
- Basic drain:
  - Stimulus: wbuf_req with addr=0x1C00_0047, line word i = 0xA000_0000+i; wr_rdy=1; w_ready=1; b_valid 2 cycles after w_last.
  - Required: wr_addr=0x1C00_0040; words 0xA000_0000..0xA000_000F appear in order on consecutive cycles; w_last only on 0xA000_000F; wbuf_done pulses once; wbuf_busy falls.
- Backpressure:
  - Stimulus: w_ready toggling 1,0,0,1,...
  - Required: w_data holds during stalls; exactly 16 handshakes; no duplicated or skipped word.
- Bridge delay:
  - Stimulus: wr_rdy held 0 for 5 cycles.
  - Required: wr_req=1 and wr_addr stable for all 5 cycles; w_valid stays 0 until after the wr_rdy cycle.
- Busy rejection:
  - Stimulus: second wbuf_req with a different line during DATA.
  - Required: the original line is transmitted intact; the second request produces no burst.
- Back-to-back lines:
  - Stimulus: wbuf_req asserted in the wbuf_done cycle.
  - Required: the new line is captured; wr_req rises the next cycle.
- Reset mid-burst:
  - Stimulus: rst pulsed after word 7.
  - Required: all outputs 0 immediately (asynchronous); no wbuf_done; a fresh request restarts from word 0.
